// File: rtl/clk_div_pkg.sv
// Shared types and constants for the integer clock-divider controller.
package clk_div_pkg;

   // Controller states: stopped, dividing, dividing with a ratio waiting for the boundary.
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_PEND = 2'd2
   } DivState_t;

   // Smallest ratio that yields a distinct high and low phase.
   localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clk_div_core.sv
// Period counter with registered tick strobe and divided level.
// Ports:
//   clk_i, rst_ni  : clock, async active-low reset
//   run_i          : counter is active this cycle (RUN or PEND)
//   keep_i         : counter will be active next cycle
//   div_i          : ratio in effect this cycle
//   div_nxt_i      : ratio in effect next cycle
//   boundary_c_o   : combinational, last cycle of the current period
//   tick_o, clk_o  : registered strobe and divided level
module clk_div_core #(
   parameter int unsigned CTR_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             run_i,
   input  logic             keep_i,
   input  logic [CTR_W-1:0] div_i,
   input  logic [CTR_W-1:0] div_nxt_i,
   output logic             boundary_c_o,
   output logic             tick_o,
   output logic             clk_o
);

   logic [CTR_W-1:0] ctr_q, ctr_d;
   logic             tick_d, clk_d;

   // div_i is never below 2, so the subtraction cannot wrap.
   assign boundary_c_o = run_i && (ctr_q == (div_i - CTR_W'(1)));

   // Next count plus outputs derived from the next cycle's count and ratio,
   // so the registered level lines up with the cycle it describes.
   always_comb begin
      ctr_d  = '0;
      tick_d = 1'b0;
      clk_d  = 1'b0;
      if (keep_i && run_i && !boundary_c_o) begin
         ctr_d = ctr_q + CTR_W'(1);
      end
      // A stop on the boundary edge suppresses the tick that would have fired.
      tick_d = boundary_c_o && keep_i;
      clk_d  = keep_i && (ctr_d < (div_nxt_i >> 1));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctr_q  <= '0;
         tick_o <= 1'b0;
         clk_o  <= 1'b0;
      end else begin
         ctr_q  <= ctr_d;
         tick_o <= tick_d;
         clk_o  <= clk_d;
      end
   end

endmodule

// File: rtl/clk_div_sched.sv
// Run-time controller for the integer clock divider: owns the ratio,
// start/stop sequencing and boundary-aligned reconfiguration.
// Ports:
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_en                   : run request
//   i_cfg_valid, i_cfg_div : ratio offer
//   o_cfg_ready            : combinational from state, offer can be taken
//   o_cfg_err              : pulse, accepted ratio was illegal
//   o_tick, o_clk          : period strobe and divided level
//   o_running, o_div       : status
module clk_div_sched
   import clk_div_pkg::*;
#(
   parameter int unsigned CTR_W       = 8,
   parameter int unsigned DEFAULT_DIV = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_cfg_valid,
   input  logic [CTR_W-1:0] i_cfg_div,
   output logic             o_cfg_ready,
   output logic             o_cfg_err,
   output logic             o_tick,
   output logic             o_clk,
   output logic             o_running,
   output logic [CTR_W-1:0] o_div
);

   DivState_t        state_q, state_d;
   logic [CTR_W-1:0] div_q, div_d;
   logic [CTR_W-1:0] div_pend_q, div_pend_d;
   logic             err_q, err_d;
   logic             running_q;

   logic             cfg_ready_c;
   logic             accept_c;
   logic             legal_c;
   logic             run_c;
   logic             keep_c;
   logic             boundary_c;

   assign cfg_ready_c = (state_q != DIV_PEND);
   assign accept_c    = i_cfg_valid && cfg_ready_c;
   assign legal_c     = (i_cfg_div >= CTR_W'(MIN_DIV));
   assign run_c       = (state_q != DIV_IDLE);
   assign keep_c      = (state_d != DIV_IDLE);

   // Next state, ratio and error pulse.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      div_pend_d = div_pend_q;
      err_d      = accept_c && !legal_c;
      case (state_q)
         DIV_IDLE: begin
            if (accept_c && legal_c) div_d = i_cfg_div;
            if (i_en) state_d = DIV_RUN;
         end
         DIV_RUN: begin
            if (!i_en) begin
               // Stopping: a ratio offered on the same edge applies directly.
               state_d = DIV_IDLE;
               if (accept_c && legal_c) div_d = i_cfg_div;
            end else if (accept_c && legal_c) begin
               div_pend_d = i_cfg_div;
               state_d    = DIV_PEND;
            end
         end
         DIV_PEND: begin
            // The held ratio is committed at the boundary or on stop, never dropped.
            if (!i_en || boundary_c) begin
               div_d   = div_pend_q;
               state_d = i_en ? DIV_RUN : DIV_IDLE;
            end
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= DIV_IDLE;
         div_q      <= CTR_W'(DEFAULT_DIV);
         div_pend_q <= '0;
         err_q      <= 1'b0;
         running_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         div_pend_q <= div_pend_d;
         err_q      <= err_d;
         running_q  <= keep_c;
      end
   end

   clk_div_core #(
      .CTR_W (CTR_W)
   ) u_core (
      .clk_i        (i_clk),
      .rst_ni       (i_rst_n),
      .run_i        (run_c),
      .keep_i       (keep_c),
      .div_i        (div_q),
      .div_nxt_i    (div_d),
      .boundary_c_o (boundary_c),
      .tick_o       (o_tick),
      .clk_o        (o_clk)
   );

   assign o_cfg_ready = cfg_ready_c;
   assign o_cfg_err   = err_q;
   assign o_running   = running_q;
   assign o_div       = div_q;

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Run-time controller for the team's integer clock dividers. It owns the divide ratio, start/stop sequencing and reconfiguration.
- Produces a 1-cycle tick strobe and a divided clock-enable level. Example: 6 MHz system clock to 1 MHz tick with D=6.
- Accepts new ratios over a valid/ready handshake. A new ratio takes effect only on a period boundary, so no output period is ever truncated or stretched mid-cycle.

Parameters:
- CTR_W, 8, width of divide ratio and counter.
- DEFAULT_DIV, 6, ratio loaded at reset. Must be 2..2^CTR_W-1.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  run request. High = divide, low = stop.
- i_cfg_valid  in  1  new ratio offered.
- i_cfg_div  in  CTR_W  offered ratio D.
- o_cfg_ready  out  1  controller can accept a ratio this cycle.
- o_cfg_err  out  1  1-cycle pulse: accepted ratio was illegal (D<2) and was discarded.
- o_tick  out  1  1-cycle strobe, once per period.
- o_clk  out  1  divided level: high for the first floor(D/2) cycles of each period.
- o_running  out  1  state is RUN or PEND.
- o_div  out  CTR_W  ratio currently in effect (div_q).

Behaviour:
- All outputs are flops. No combinational path from any input to any output except o_cfg_ready, which depends only on state.
- Reset (async assert, sync release):
  - state=IDLE, ctr=0, div_q=DEFAULT_DIV, div_pend=0.
  - o_tick=0, o_clk=0, o_cfg_err=0, o_running=0.
  - o_cfg_ready=1.
- Reset mid-operation aborts immediately; any pending ratio is lost.
- States:
  - IDLE: ctr held 0, o_tick=0, o_clk=0. When i_en=1, move to RUN next edge with ctr=0.
  - RUN: ctr counts 0..div_q-1 and wraps to 0.
  - PEND: same counting as RUN; a legal ratio is held in div_pend.
- Handshake:
  - Accept when i_cfg_valid && o_cfg_ready.
  - o_cfg_ready=1 in IDLE and RUN, 0 in PEND.
  - Illegal D (0 or 1) on accept: o_cfg_err=1 the following cycle, no state or div change.
- Legal accept in IDLE: div_q<=i_cfg_div next edge.
- Legal accept in RUN: div_pend<=i_cfg_div, state<=PEND.
- PEND resolves at the boundary (cycle with ctr==div_q-1):
  - div_q<=div_pend, ctr<=0, state<=RUN.
  - o_tick fires for the old period as normal.
- Tick timing:
  - o_tick is registered from (RUN/PEND && ctr==div_q-1).
  - It is therefore high in the cycle ctr==0 of the next period.
  - First tick comes exactly D cycles after the first RUN cycle, then every D cycles.
- Divided level: o_clk is high in exactly those RUN/PEND cycles where ctr < div_q>>1.
  - D=6: 3 high, 3 low.
  - D=5: 2 high, 3 low.
  - D=2: 1 high, 1 low.
- Stop: i_en=0 in RUN/PEND moves to IDLE next edge, ctr=0, o_clk=0, o_tick=0.
  - A tick already due on that edge is suppressed.
  - In PEND, div_pend is committed to div_q on the stop edge; it is not discarded.
- Simultaneous events:
  - i_en fall + legal accept in RUN: state goes IDLE and div_q<=i_cfg_div on the same edge.
  - i_en rise + accept in IDLE: state goes RUN with the new div_q; first period uses the new ratio.
- Arithmetic: ctr is CTR_W bits, compare unsigned. Boundary compare uses div_q-1 and never underflows (div_q>=2 guaranteed).
- o_running=1 iff state is RUN or PEND (registered with state).

Decomposition:
- Package clk_div_pkg:
  - typedef enum logic[1:0] {DIV_IDLE, DIV_RUN, DIV_PEND} DivState_t.
  - localparam MIN_DIV=2.
- One natural sub-module: clk_div_core, the counter plus o_tick/o_clk generation.
  - Inputs: run, div. Output: boundary flag.
  - The handshake/FSM stays in clk_div_sched.

Test Plan:
- Reset to run:
  - Reset, hold i_en=1 for 30 cycles.
  - o_tick pulses at cycles 6, 12, 18, 24 after the first RUN cycle.
  - o_clk pattern 111000 repeating; o_div=6.
- Config in IDLE:
  - In IDLE offer D=4, then raise i_en.
  - Ticks every 4 cycles; o_clk 1100; o_cfg_ready high throughout.
- Mid-period reconfig:
  - Running D=6 with ctr=2, offer D=3.
  - Accepted, o_cfg_ready low 3 cycles (PEND); current period completes at 6.
  - Next ticks 3 cycles apart; o_clk 100.
- Illegal ratio:
  - Offer D=1 while running D=6.
  - o_cfg_err pulses once; ticks stay every 6 cycles; o_div stays 6.
- Stop during PEND:
  - Running D=6, offer D=8, drop i_en the next cycle.
  - IDLE next edge, no further ticks, o_div=8.
  - Re-enable: ticks every 8 cycles.
- Async reset mid-run:
  - Assert i_rst_n=0 between clock edges with ctr=4.
  - All outputs 0 immediately, o_div=DEFAULT_DIV.
  - After release, no tick until i_en has been high 6 cycles.
